uart_tx: RTL and testbench

Serial UART transmitter: the transmit-side counterpart of the existing UART receive path. It accepts one byte through a valid/ready handshake and serialises it onto a single line as 8N1 at BAUD_RATE. The frame is a start bit, data bits LSB-first, an optional parity bit, then a stop bit. It sits between the system-side byte producer and the board TX pin and pairs with the Rx path, which shares the same SYS_CLK and BAUD_RATE.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the Tx and Rx paths.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after the data bits).
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // Truncating division; Rx and Tx must agree on this exactly.
    function automatic int clks_per_bit(input int sys_clk, input int baud_rate);
        return sys_clk / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_done marks the last clock of each bit period.
// Synchronous clear lets the FSM restart the period on every state change.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_done = (count == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, start + 8 data bits LSB-first + stop.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit before stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int SYS_CLK   = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_d,
    output logic       o_tx_ready,
    output logic       o_tx_d,
    output logic       o_tx_busy,
    output logic       o_tx_complete
);

    localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK, BAUD_RATE);
    localparam int BIT_W        = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end

    state_t                 state;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   bit_done;
    logic                   baud_clear;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    // Every non-idle transition happens on bit_done, so clearing on it restarts each bit cleanly.
    assign baud_clear = (state == IDLE) || bit_done;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clear),
        .bit_done (bit_done)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is reset too; it is a handful of flops, not a memory array.
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
            o_tx_d        <= 1'b1;
            o_tx_ready    <= 1'b1;
            o_tx_busy     <= 1'b0;
            o_tx_complete <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit    <= 1'b0;
`endif
        end else begin
            o_tx_complete <= 1'b0;
            case (state)
                IDLE: begin
                    o_tx_d     <= 1'b1;
                    o_tx_ready <= 1'b1;
                    o_tx_busy  <= 1'b0;
                    if (i_tx_valid) begin
                        shift_reg  <= i_tx_d;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^i_tx_d;
`endif
                        bit_cnt    <= '0;
                        o_tx_d     <= 1'b0;
                        o_tx_ready <= 1'b0;
                        o_tx_busy  <= 1'b1;
                        state      <= START;
                    end
                end

                START: begin
                    if (bit_done) begin
                        o_tx_d    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            o_tx_d <= parity_bit;
                            state  <= PARITY;
`else
                            o_tx_d <= 1'b1;
                            state  <= STOP;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            o_tx_d    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        o_tx_d <= 1'b1;
                        state  <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (bit_done) begin
                        o_tx_d        <= 1'b1;
                        o_tx_ready    <= 1'b1;
                        o_tx_busy     <= 1'b0;
                        o_tx_complete <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    o_tx_d     <= 1'b1;
                    o_tx_ready <= 1'b1;
                    o_tx_busy  <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT = 10; frame timing is checked cycle by cycle.
// Build with UART_TX_PARITY_EN defined to also cover the parity frames.
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       i_tx_valid;
    logic [7:0] i_tx_d;
    logic       o_tx_ready;
    logic       o_tx_d;
    logic       o_tx_busy;
    logic       o_tx_complete;

    int vectors     = 0;
    int miscompares = 0;
    int complete_cnt = 0;

    uart_tx #(
        .SYS_CLK   (1000000),
        .BAUD_RATE (100000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_tx_valid    (i_tx_valid),
        .i_tx_d        (i_tx_d),
        .o_tx_ready    (o_tx_ready),
        .o_tx_d        (o_tx_d),
        .o_tx_busy     (o_tx_busy),
        .o_tx_complete (o_tx_complete)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_tx_complete === 1'b1) complete_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level in cycle c, counting the acceptance edge as cycle 0.
    function automatic logic exp_line(input logic [7:0] b, input int c);
        if (c >= 1 && c <= CPB) return 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (c >= (k + 1) * CPB + 1 && c <= (k + 2) * CPB) return b[k];
        end
`ifdef UART_TX_PARITY_EN
        if (c >= 9 * CPB + 1 && c <= 10 * CPB) return ^b;
`endif
        return 1'b1;
    endfunction

    // Caller has valid/data set up; the next edge is the acceptance edge.
    task automatic run_frame(input logic [7:0] b, input string tag, input bit hold,
                             input logic [7:0] next_d, input bit disturb,
                             output logic par_seen);
        logic [7:0] decoded;
        int line_err;
        int busy_err;
        decoded  = '0;
        par_seen = 1'b0;
        line_err = 0;
        busy_err = 0;
        tick();
        if (hold) i_tx_d = next_d;
        else      i_tx_valid = 1'b0;
        for (int c = 1; c <= FRAME * CPB; c++) begin
            if (c > 1) tick();
            if (disturb && c == 35) begin
                i_tx_valid = 1'b1;
                i_tx_d     = 8'hFF;
            end
            if (disturb && c == 36) i_tx_valid = 1'b0;
            if (o_tx_d !== exp_line(b, c)) begin
                line_err++;
                if (line_err == 1) check({tag, "_line"}, {24'd0, 7'd0, o_tx_d}, {31'd0, exp_line(b, c)});
            end
            if (o_tx_busy !== 1'b1) busy_err++;
            for (int k = 0; k < 8; k++) begin
                if (c == (k + 1) * CPB + CPB / 2) decoded[k] = o_tx_d;
            end
            if (c == 9 * CPB + CPB / 2) par_seen = o_tx_d;
        end
        check({tag, "_line_errors"}, line_err, 0);
        check({tag, "_busy_errors"}, busy_err, 0);
        tick();
        check({tag, "_complete"}, {31'd0, o_tx_complete}, 1);
        check({tag, "_ready_end"}, {31'd0, o_tx_ready}, 1);
        check({tag, "_busy_end"},  {31'd0, o_tx_busy}, 0);
        check({tag, "_idle_line"}, {31'd0, o_tx_d}, 1);
        check({tag, "_decoded"},   {24'd0, decoded}, {24'd0, b});
    endtask

    initial begin
        logic par;
        int   c0;
        rst        = 1'b1;
        i_tx_valid = 1'b0;
        i_tx_d     = 8'h00;
        repeat (3) tick();

        // Reset state and a quiet idle period.
        check("rst_line",     {31'd0, o_tx_d}, 1);
        check("rst_ready",    {31'd0, o_tx_ready}, 1);
        check("rst_busy",     {31'd0, o_tx_busy}, 0);
        check("rst_complete", {31'd0, o_tx_complete}, 0);
        rst = 1'b0;
        c0  = complete_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_tx_d !== 1'b1 || o_tx_ready !== 1'b1 || o_tx_busy !== 1'b0)
                check("idle_outputs", {29'd0, o_tx_d, o_tx_ready, o_tx_busy}, 32'b110);
        end
        check("idle_line",     {31'd0, o_tx_d}, 1);
        check("idle_ready",    {31'd0, o_tx_ready}, 1);
        check("idle_no_pulse", complete_cnt - c0, 0);

        // Single frame of 0x55.
        i_tx_valid = 1'b1;
        i_tx_d     = 8'h55;
        run_frame(8'h55, "b55", 1'b0, 8'h00, 1'b0, par);
        repeat (2) tick();

        // Back-to-back: valid held, second byte accepted in the first idle cycle.
        i_tx_valid = 1'b1;
        i_tx_d     = 8'hA5;
        run_frame(8'hA5, "bA5", 1'b1, 8'h3C, 1'b0, par);
        run_frame(8'h3C, "b3C", 1'b0, 8'h00, 1'b0, par);
        repeat (2) tick();

        // Mid-frame valid pulse and data change must not disturb 0x12.
        c0         = complete_cnt;
        i_tx_valid = 1'b1;
        i_tx_d     = 8'h12;
        run_frame(8'h12, "b12", 1'b0, 8'h00, 1'b1, par);
        repeat (5) tick();
        check("b12_one_pulse",  complete_cnt - c0, 1);
        check("b12_idle_after", {31'd0, o_tx_d}, 1);
        check("b12_ready_after", {31'd0, o_tx_ready}, 1);

        // Reset at cycle 45 of a 0xC3 frame (data bit 3 = 0 on the line).
        c0         = complete_cnt;
        i_tx_valid = 1'b1;
        i_tx_d     = 8'hC3;
        tick();
        i_tx_valid = 1'b0;
        repeat (44) tick();
        check("mid_frame_line", {31'd0, o_tx_d}, 0);
        check("mid_frame_busy", {31'd0, o_tx_busy}, 1);
        rst = 1'b1;
        tick();
        check("abort_line",     {31'd0, o_tx_d}, 1);
        check("abort_ready",    {31'd0, o_tx_ready}, 1);
        check("abort_busy",     {31'd0, o_tx_busy}, 0);
        check("abort_complete", {31'd0, o_tx_complete}, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("abort_no_pulse", complete_cnt - c0, 0);
        i_tx_valid = 1'b1;
        i_tx_d     = 8'h81;
        run_frame(8'h81, "b81", 1'b0, 8'h00, 1'b0, par);
        repeat (2) tick();

`ifdef UART_TX_PARITY_EN
        i_tx_valid = 1'b1;
        i_tx_d     = 8'h07;
        run_frame(8'h07, "p07", 1'b0, 8'h00, 1'b0, par);
        check("p07_parity", {31'd0, par}, 1);
        repeat (2) tick();
        i_tx_valid = 1'b1;
        i_tx_d     = 8'h03;
        run_frame(8'h03, "p03", 1'b0, 8'h00, 1'b0, par);
        check("p03_parity", {31'd0, par}, 0);
        repeat (2) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
